// File: rtl/fp_align_swap_if.sv
// fp_align_swap_if: handshake and operand/result bus of the FP32 add/sub alignment front-end.
//   Upstream side:   i_valid, o_ready, i_data_a, i_data_b
//   Downstream side: o_valid, i_ready, o_swap, o_eff_sub, o_sign_large, o_sign_small,
//                    o_exp_large, o_mant_large, o_mant_small
//   master drives operands and downstream ready; slave is the alignment block.
interface fp_align_swap_if #(
  parameter int SIZE_DATA = 32,
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_MANT = 28
);
  logic                 i_valid;
  logic                 o_ready;
  logic [SIZE_DATA-1:0] i_data_a;
  logic [SIZE_DATA-1:0] i_data_b;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_swap;
  logic                 o_eff_sub;
  logic                 o_sign_large;
  logic                 o_sign_small;
  logic [SIZE_EXP-1:0]  o_exp_large;
  logic [SIZE_MANT-1:0] o_mant_large;
  logic [SIZE_MANT-1:0] o_mant_small;
  modport master (
    output i_valid, i_data_a, i_data_b, i_ready,
    input  o_ready, o_valid, o_swap, o_eff_sub, o_sign_large, o_sign_small,
           o_exp_large, o_mant_large, o_mant_small
  );
  modport slave (
    input  i_valid, i_data_a, i_data_b, i_ready,
    output o_ready, o_valid, o_swap, o_eff_sub, o_sign_large, o_sign_small,
           o_exp_large, o_mant_large, o_mant_small
  );
endinterface

// File: rtl/fp_align_swap.sv
// fp_align_swap: orders two FP32 operands by magnitude and right-aligns the smaller mantissa.
//   i_clk   : clock, all flops on rising edge
//   i_rst_n : asynchronous active-low reset, flushes both pipeline stages
//   bus     : fp_align_swap_if.slave, operand input handshake and aligned result output handshake
// Stage 1 decodes, compares and swaps; stage 2 shifts the small mantissa with sticky collection.
module fp_align_swap #(
  parameter int SIZE_DATA = 32,
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_MANT = 28
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  fp_align_swap_if.slave      bus
);
  localparam int SIZE_FRAC = SIZE_DATA - SIZE_EXP - 1;
  logic                 s1_valid;
  logic                 s1_sign_large;
  logic                 s1_sign_small;
  logic                 s1_swap;
  logic                 s1_eff_sub;
  logic [SIZE_EXP-1:0]  s1_exp_large;
  logic [SIZE_EXP-1:0]  s1_shamt;
  logic [SIZE_MANT-1:0] s1_mant_large;
  logic [SIZE_MANT-1:0] s1_mant_small;
  logic                 s1_load;
  logic                 s2_load;
  logic                 swap;
  logic [SIZE_DATA-1:0] op_large;
  logic [SIZE_DATA-1:0] op_small;
  logic [SIZE_EXP-1:0]  exp_large;
  logic [SIZE_EXP-1:0]  exp_small;
  logic [SIZE_MANT-1:0] shifted;
  logic [SIZE_MANT-1:0] lost_mask;
  logic                 sticky;
  logic [SIZE_MANT-1:0] aligned;

  function automatic logic [SIZE_EXP-1:0] exp_eff(input logic [SIZE_DATA-1:0] x);
    logic [SIZE_EXP-1:0] e;
    e = x[SIZE_DATA-2 -: SIZE_EXP];
    return (e == '0) ? SIZE_EXP'(1) : e;
  endfunction

  function automatic logic [SIZE_MANT-1:0] mant_ext(input logic [SIZE_DATA-1:0] x);
    return {1'b0, |x[SIZE_DATA-2 -: SIZE_EXP], x[SIZE_FRAC-1:0], 3'b000};
  endfunction

  // Output stage takes new data when empty or when its result is being consumed.
  assign s2_load   = ~bus.o_valid | bus.i_ready;
  assign s1_load   = ~s1_valid | s2_load;
  assign bus.o_ready = s1_load;

  // {exp, frac} as an unsigned integer orders magnitudes; ties keep A on the large lane.
  assign swap      = bus.i_data_b[SIZE_DATA-2:0] > bus.i_data_a[SIZE_DATA-2:0];
  assign op_large  = swap ? bus.i_data_b : bus.i_data_a;
  assign op_small  = swap ? bus.i_data_a : bus.i_data_b;
  assign exp_large = exp_eff(op_large);
  assign exp_small = exp_eff(op_small);

  // Far shifts collapse to a pure sticky bit; otherwise fold shifted-out bits into bit 0.
  assign shifted   = s1_mant_small >> s1_shamt;
  assign lost_mask = (SIZE_MANT'(1) << s1_shamt) - SIZE_MANT'(1);
  assign sticky    = |(s1_mant_small & lost_mask);
  assign aligned   = (s1_shamt >= SIZE_EXP'(SIZE_MANT - 1))
                   ? {{(SIZE_MANT-1){1'b0}}, |s1_mant_small}
                   : {shifted[SIZE_MANT-1:1], shifted[0] | sticky};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid      <= 1'b0;
      s1_sign_large <= 1'b0;
      s1_sign_small <= 1'b0;
      s1_swap       <= 1'b0;
      s1_eff_sub    <= 1'b0;
      s1_exp_large  <= '0;
      s1_shamt      <= '0;
      s1_mant_large <= '0;
      s1_mant_small <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_sign_large <= op_large[SIZE_DATA-1];
        s1_sign_small <= op_small[SIZE_DATA-1];
        s1_swap       <= swap;
        s1_eff_sub    <= bus.i_data_a[SIZE_DATA-1] ^ bus.i_data_b[SIZE_DATA-1];
        s1_exp_large  <= exp_large;
        s1_shamt      <= exp_large - exp_small;
        s1_mant_large <= mant_ext(op_large);
        s1_mant_small <= mant_ext(op_small);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_valid      <= 1'b0;
      bus.o_swap       <= 1'b0;
      bus.o_eff_sub    <= 1'b0;
      bus.o_sign_large <= 1'b0;
      bus.o_sign_small <= 1'b0;
      bus.o_exp_large  <= '0;
      bus.o_mant_large <= '0;
      bus.o_mant_small <= '0;
    end else if (s2_load) begin
      bus.o_valid <= s1_valid;
      if (s1_valid) begin
        bus.o_swap       <= s1_swap;
        bus.o_eff_sub    <= s1_eff_sub;
        bus.o_sign_large <= s1_sign_large;
        bus.o_sign_small <= s1_sign_small;
        bus.o_exp_large  <= s1_exp_large;
        bus.o_mant_large <= s1_mant_large;
        bus.o_mant_small <= aligned;
      end
    end
  end
endmodule

// File: tb/tb_fp_align_swap.sv
// tb_fp_align_swap: directed-vector bench for fp_align_swap with a queue-based reference model.
module tb_fp_align_swap;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  fp_align_swap_if bus();
  fp_align_swap dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct packed {
    logic        swap;
    logic        eff_sub;
    logic        sign_large;
    logic        sign_small;
    logic [7:0]  exp_large;
    logic [27:0] mant_large;
    logic [27:0] mant_small;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    res_t        r;
  } vec_t;

  int compared = 0;
  int mismatched = 0;
  res_t q[$];
  res_t held_val;
  logic held = 1'b0;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: order by magnitude, then align with integer division semantics.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [31:0] l, s;
    int el, es, ml, ms, sh, rs;
    r.swap = b[30:0] > a[30:0];
    l = r.swap ? b : a;
    s = r.swap ? a : b;
    el = (l[30:23] == 8'd0) ? 1 : int'(l[30:23]);
    es = (s[30:23] == 8'd0) ? 1 : int'(s[30:23]);
    ml = ((l[30:23] != 8'd0) ? (1 << 26) : 0) + int'(l[22:0]) * 8;
    ms = ((s[30:23] != 8'd0) ? (1 << 26) : 0) + int'(s[22:0]) * 8;
    sh = el - es;
    if (sh >= 27) rs = (ms != 0) ? 1 : 0;
    else rs = (ms / (1 << sh)) | (((ms % (1 << sh)) != 0) ? 1 : 0);
    r.eff_sub = a[31] ^ b[31];
    r.sign_large = l[31];
    r.sign_small = s[31];
    r.exp_large = 8'(el);
    r.mant_large = 28'(ml);
    r.mant_small = 28'(rs);
    return r;
  endfunction

  function automatic res_t cur();
    res_t r;
    r.swap = bus.o_swap;
    r.eff_sub = bus.o_eff_sub;
    r.sign_large = bus.o_sign_large;
    r.sign_small = bus.o_sign_small;
    r.exp_large = bus.o_exp_large;
    r.mant_large = bus.o_mant_large;
    r.mant_small = bus.o_mant_small;
    return r;
  endfunction

  task automatic cmp_res(input string tag, input res_t act, input res_t exp);
    chk({tag, "_flags"}, 32'({act.swap, act.eff_sub, act.sign_large, act.sign_small}),
        32'({exp.swap, exp.eff_sub, exp.sign_large, exp.sign_small}));
    chk({tag, "_exp_large"}, 32'(act.exp_large), 32'(exp.exp_large));
    chk({tag, "_mant_large"}, 32'(act.mant_large), 32'(exp.mant_large));
    chk({tag, "_mant_small"}, 32'(act.mant_small), 32'(exp.mant_small));
  endtask

  // Inputs change 1 time unit after posedge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (rst_n) begin
      if (held) begin
        chk("hold_valid", 32'(bus.o_valid), 32'd1);
        cmp_res("hold", cur(), held_val);
      end
      if (bus.i_valid && bus.o_ready) q.push_back(model(bus.i_data_a, bus.i_data_b));
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_result: got a result, expected none");
        end else begin
          cmp_res("result", cur(), q.pop_front());
        end
      end
      held = bus.o_valid && !bus.i_ready;
      held_val = cur();
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    bus.i_valid = 1'b1;
    bus.i_data_a = a;
    bus.i_data_b = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.o_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got no accept, expected accept within 50 cycles");
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.i_ready = 1'b1;
    while ((q.size() != 0 || bus.o_valid) && n < 30) begin
      @(posedge clk);
      #2;
      n++;
    end
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
  endtask

  initial begin
    logic [7:0] pat;
    pat = 8'b1011_0010;
    vecs[0]  = '{32'h40000000, 32'h3F800000, '{1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 28'h4000000, 28'h2000000}};
    vecs[1]  = '{32'h3F800000, 32'hC0000000, '{1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 28'h4000000, 28'h2000000}};
    vecs[2]  = '{32'h4B000000, 32'h3F800001, '{1'b0, 1'b0, 1'b0, 1'b0, 8'h96, 28'h4000000, 28'h0000009}};
    vecs[3]  = '{32'h64000000, 32'h3F800000, '{1'b0, 1'b0, 1'b0, 1'b0, 8'hC8, 28'h4000000, 28'h0000001}};
    vecs[4]  = '{32'h3F800000, 32'hBF800000, '{1'b0, 1'b1, 1'b0, 1'b1, 8'h7F, 28'h4000000, 28'h4000000}};
    vecs[5]  = '{32'h00000001, 32'h00000002, '{1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 28'h0000010, 28'h0000008}};
    vecs[6]  = '{32'h7F800000, 32'h3F800000, '{1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 28'h4000000, 28'h0000001}};
    vecs[7]  = '{32'h00000000, 32'h80000000, '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 28'h0000000, 28'h0000000}};
    vecs[8]  = '{32'h3FC00000, 32'h40400000, '{1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 28'h6000000, 28'h3000000}};
    vecs[9]  = '{32'h4D000000, 32'h3F800000, '{1'b0, 1'b0, 1'b0, 1'b0, 8'h9A, 28'h4000000, 28'h0000001}};
    vecs[10] = '{32'h4C000000, 32'h3F800000, '{1'b0, 1'b0, 1'b0, 1'b0, 8'h98, 28'h4000000, 28'h0000002}};
    for (int i = 0; i < 11; i++) cmp_res($sformatf("pin%0d", i), model(vecs[i].a, vecs[i].b), vecs[i].r);

    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_data_a = '0;
    bus.i_data_b = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(bus.o_valid), 32'd0);
    chk("reset_mant_large", 32'(bus.o_mant_large), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", 32'(bus.o_ready), 32'd1);

    // First transaction latency: visible after the second rising edge.
    @(posedge clk);
    #1;
    bus.i_valid = 1'b1;
    bus.i_data_a = vecs[0].a;
    bus.i_data_b = vecs[0].b;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    chk("latency_cycle1_valid", 32'(bus.o_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_cycle2_valid", 32'(bus.o_valid), 32'd1);
    chk("latency_mant_small", 32'(bus.o_mant_small), 32'h2000000);

    for (int i = 1; i < 11; i++) send(vecs[i].a, vecs[i].b);
    drain();

    // Irregular downstream ready while streaming every vector.
    fork
      for (int i = 0; i < 11; i++) send(vecs[i].a, vecs[i].b);
      for (int k = 0; k < 40; k++) begin
        @(posedge clk);
        #1;
        bus.i_ready = pat[k % 8];
      end
    join
    drain();

    // Backpressure: two accepted, third stalls until the first drains.
    bus.i_ready = 1'b0;
    send(vecs[2].a, vecs[2].b);
    send(vecs[5].a, vecs[5].b);
    bus.i_valid = 1'b1;
    bus.i_data_a = vecs[8].a;
    bus.i_data_b = vecs[8].b;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(bus.o_ready), 32'd0);
      chk("bp_valid_high", 32'(bus.o_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.i_ready = 1'b1;
    #1;
    chk("bp_accept_during_drain", 32'(bus.o_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    drain();

    // Asynchronous reset with both stages full.
    bus.i_ready = 1'b0;
    send(vecs[0].a, vecs[0].b);
    send(vecs[1].a, vecs[1].b);
    @(negedge clk);
    chk("pre_reset_ready", 32'(bus.o_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    q.delete();
    held = 1'b0;
    #1;
    chk("async_reset_valid", 32'(bus.o_valid), 32'd0);
    chk("async_reset_swap", 32'(bus.o_swap), 32'd0);
    chk("async_reset_exp", 32'(bus.o_exp_large), 32'd0);
    chk("async_reset_mant_large", 32'(bus.o_mant_large), 32'd0);
    chk("async_reset_mant_small", 32'(bus.o_mant_small), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", 32'(bus.o_ready), 32'd1);
    bus.i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_stale_valid", 32'(bus.o_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(vecs[3].a, vecs[3].b);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
